mem_bus_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of memory_bus. Lets the CPU core (port 0) and a second master, e.g. an SPI program loader or DMA engine (port 1), share one ROM/RAM/peripheral bus.
- Grants one transaction at a time, round-robin between the ports.
- Drives bus_enable/write_enable for exactly one cycle per transaction, waits MEM_LATENCY cycles, then captures read data and returns it with a done pulse.

---
 rtl/mem_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-port round-robin arbiter and sequencer in front of memory_bus.
//
// Port 0 (CPU core) and port 1 (loader/DMA master) share one ROM/RAM/peripheral bus.
// One transaction is in flight at a time:
//   IDLE  -> pick a requester, latch its fields onto the bus registers
//   ISSUE -> bus_enable (and write_enable for writes) high for this one cycle, grant pulse
//   WAIT  -> MEM_LATENCY cycles; read data captured in the last of them
//   DONE  -> done pulse to the selected port
//
// Parameters:
//   MEM_LATENCY  cycles from the bus_enable cycle until bus_data_out is valid (1..7)
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   mN_req                      request, held with stable fields until mN_done
//   mN_address/_write_enable    transaction address and direction (1 = write)
//   mN_write_data/_write_mask   write data and per-byte mask (1 = preserve lane)
//   mN_grant                    one-cycle pulse in port N's issue cycle
//   mN_done                     one-cycle pulse when port N's transaction completes
//   mN_read_data                last read data returned to port N
//   bus_*                       memory_bus address/data/mask/enable/write_enable
//   bus_data_out                memory_bus read data
//   busy                        high whenever a transaction is in flight
module mem_bus_arbiter #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic [15:0] m0_address,
  input  logic        m0_write_enable,
  input  logic [31:0] m0_write_data,
  input  logic [3:0]  m0_write_mask,
  output logic        m0_grant,
  output logic        m0_done,
  output logic [31:0] m0_read_data,

  input  logic        m1_req,
  input  logic [15:0] m1_address,
  input  logic        m1_write_enable,
  input  logic [31:0] m1_write_data,
  input  logic [3:0]  m1_write_mask,
  output logic        m1_grant,
  output logic        m1_done,
  output logic [31:0] m1_read_data,

  output logic [15:0] bus_address,
  output logic [31:0] bus_data_in,
  output logic [3:0]  bus_write_mask,
  output logic        bus_enable,
  output logic        bus_write_enable,
  input  logic [31:0] bus_data_out,

  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam logic [2:0] LatCount = 3'(MEM_LATENCY);

  state_e     state_q;
  logic       last_grant_q;  // port granted most recently; the other one wins a tie
  logic       sel_q;         // port owning the transaction in flight
  logic       we_q;          // direction of the transaction in flight
  logic [2:0] count_q;       // remaining WAIT cycles
  logic       pick;

  // Lone requester wins; on a tie the port that was not granted last wins.
  assign pick = m1_req & (~m0_req | ~last_grant_q);

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      last_grant_q     <= 1'b1;
      sel_q            <= 1'b0;
      we_q             <= 1'b0;
      count_q          <= 3'd0;
      bus_address      <= 16'h0000;
      bus_data_in      <= 32'h0000_0000;
      bus_write_mask   <= 4'hf;
      bus_enable       <= 1'b0;
      bus_write_enable <= 1'b0;
      m0_grant         <= 1'b0;
      m1_grant         <= 1'b0;
      m0_done          <= 1'b0;
      m1_done          <= 1'b0;
      m0_read_data     <= 32'h0000_0000;
      m1_read_data     <= 32'h0000_0000;
    end else begin
      // Pulsed outputs default low; only the transitions below raise them.
      m0_grant         <= 1'b0;
      m1_grant         <= 1'b0;
      m0_done          <= 1'b0;
      m1_done          <= 1'b0;
      bus_enable       <= 1'b0;
      bus_write_enable <= 1'b0;

      case (state_q)
        StIdle: begin
          if (m0_req || m1_req) begin
            sel_q        <= pick;
            last_grant_q <= pick;
            count_q      <= LatCount;
            bus_enable   <= 1'b1;
            state_q      <= StIssue;
            if (pick) begin
              bus_address      <= m1_address;
              bus_data_in      <= m1_write_data;
              bus_write_mask   <= m1_write_mask;
              we_q             <= m1_write_enable;
              bus_write_enable <= m1_write_enable;
              m1_grant         <= 1'b1;
            end else begin
              bus_address      <= m0_address;
              bus_data_in      <= m0_write_data;
              bus_write_mask   <= m0_write_mask;
              we_q             <= m0_write_enable;
              bus_write_enable <= m0_write_enable;
              m0_grant         <= 1'b1;
            end
          end
        end

        StIssue: begin
          state_q <= StWait;
        end

        StWait: begin
          count_q <= count_q - 3'd1;
          if (count_q == 3'd1) begin
            // Last WAIT cycle: bus_data_out is valid now.
            if (!we_q) begin
              if (sel_q) m1_read_data <= bus_data_out;
              else       m0_read_data <= bus_data_out;
            end
            if (sel_q) m1_done <= 1'b1;
            else       m0_done <= 1'b1;
            state_q <= StDone;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (MEM_LATENCY = 3).
// A transaction-level model predicts every output from the grant time of the
// transaction in flight; directed scenarios add literal expectations, followed
// by randomized masters, random bus data and occasional resets.
module tb_mem_bus_arbiter;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] addr   [2];
  logic [1:0]  we;
  logic [31:0] wdata  [2];
  logic [3:0]  wmask  [2];
  logic [1:0]  grant;
  logic [1:0]  done;
  logic [31:0] rdata  [2];
  logic [15:0] bus_address;
  logic [31:0] bus_data_in;
  logic [3:0]  bus_write_mask;
  logic        bus_enable;
  logic        bus_write_enable;
  logic [31:0] bus_data_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MEM_LATENCY(L)) dut (
    .clk              (clk),
    .reset            (reset),
    .m0_req           (req[0]),
    .m0_address       (addr[0]),
    .m0_write_enable  (we[0]),
    .m0_write_data    (wdata[0]),
    .m0_write_mask    (wmask[0]),
    .m0_grant         (grant[0]),
    .m0_done          (done[0]),
    .m0_read_data     (rdata[0]),
    .m1_req           (req[1]),
    .m1_address       (addr[1]),
    .m1_write_enable  (we[1]),
    .m1_write_data    (wdata[1]),
    .m1_write_mask    (wmask[1]),
    .m1_grant         (grant[1]),
    .m1_done          (done[1]),
    .m1_read_data     (rdata[1]),
    .bus_address      (bus_address),
    .bus_data_in      (bus_data_in),
    .bus_write_mask   (bus_write_mask),
    .bus_enable       (bus_enable),
    .bus_write_enable (bus_write_enable),
    .bus_data_out     (bus_data_out),
    .busy             (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          cyc = 0;
  bit          model_ready = 0;
  bit          m_active = 0;
  int          m_g = 0;        // cycle in which the current transaction was granted
  bit          m_sel = 0;
  bit          m_last = 1;
  bit          m_we = 0;
  logic [15:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_mask = 4'hf;
  logic [31:0] m_rd [2];
  logic [1:0]  e_grant = '0, e_done = '0;
  bit          e_en = 0, e_bwe = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_active = 0; m_last = 1; m_sel = 0; m_we = 0;
      m_addr = '0; m_data = '0; m_mask = 4'hf;
      m_rd[0] = '0; m_rd[1] = '0;
    end else begin
      // Data is valid in cycle grant+L; done follows in grant+L+1.
      if (m_active && !m_we && (cyc - 1 == m_g + L)) m_rd[m_sel] = bus_data_out;
      if (m_active && (cyc - 1 == m_g + L + 1)) m_active = 0;
      else if (!m_active && (req[0] || req[1])) begin
        m_sel    = (req[0] && req[1]) ? !m_last : req[1];
        m_last   = m_sel;
        m_g      = cyc;
        m_active = 1;
        m_addr   = addr[m_sel];
        m_data   = wdata[m_sel];
        m_mask   = wmask[m_sel];
        m_we     = we[m_sel];
      end
    end
    e_en       = m_active && (cyc == m_g);
    e_bwe      = e_en && m_we;
    e_grant[0] = e_en && !m_sel;
    e_grant[1] = e_en && m_sel;
    e_done[0]  = m_active && (cyc == m_g + L + 1) && !m_sel;
    e_done[1]  = m_active && (cyc == m_g + L + 1) && m_sel;
    model_ready = 1;
  end

  always @(negedge clk) begin
    if (model_ready) begin
      chk("grant0", 32'(grant[0]), 32'(e_grant[0]));
      chk("grant1", 32'(grant[1]), 32'(e_grant[1]));
      chk("done0", 32'(done[0]), 32'(e_done[0]));
      chk("done1", 32'(done[1]), 32'(e_done[1]));
      chk("rdata0", rdata[0], m_rd[0]);
      chk("rdata1", rdata[1], m_rd[1]);
      chk("bus_en", 32'(bus_enable), 32'(e_en));
      chk("bus_we", 32'(bus_write_enable), 32'(e_bwe));
      chk("bus_addr", 32'(bus_address), 32'(m_addr));
      chk("bus_data", bus_data_in, m_data);
      chk("bus_mask", 32'(bus_write_mask), 32'(m_mask));
      chk("busy", 32'(busy), 32'(m_active));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    bus_data_out = $urandom;
  endtask

  task automatic new_fields(input int k);
    addr[k]  = 16'($urandom);
    we[k]    = 1'($urandom_range(1));
    wdata[k] = $urandom;
    wmask[k] = 4'($urandom);
  endtask

  int order[$];
  int g0[$];
  int g1[$];

  initial begin
    reset = 1'b1;
    req = '0; we = '0;
    for (int k = 0; k < 2; k++) begin
      addr[k] = '0; wdata[k] = '0; wmask[k] = '0;
    end
    bus_data_out = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state.
    chk("lit_rst_busy", 32'(busy), 32'd0);
    chk("lit_rst_mask", 32'(bus_write_mask), 32'hf);
    chk("lit_rst_en", 32'(bus_enable), 32'd0);
    chk("lit_rst_rd0", rdata[0], 32'd0);

    // m0 read of 0x4000, data valid only in cycle 4.
    req[0] = 1'b1; addr[0] = 16'h4000; we[0] = 1'b0;
    wdata[0] = 32'hdead_beef; wmask[0] = 4'h0;
    tick();  // cycle 1
    chk("lit_rd_grant0", 32'(grant[0]), 32'd1);
    chk("lit_rd_en", 32'(bus_enable), 32'd1);
    chk("lit_rd_addr", 32'(bus_address), 32'h4000);
    chk("lit_rd_grant1", 32'(grant[1]), 32'd0);
    tick(); tick(); tick();  // cycle 4
    bus_data_out = 32'h1234_5678;
    tick();  // cycle 5
    chk("lit_rd_done0", 32'(done[0]), 32'd1);
    chk("lit_rd_data0", rdata[0], 32'h1234_5678);
    chk("lit_rd_busy", 32'(busy), 32'd1);
    req[0] = 1'b0;
    tick();  // cycle 6
    chk("lit_rd_idle", 32'(busy), 32'd0);

    // m1 byte write.
    req[1] = 1'b1; addr[1] = 16'h8002; we[1] = 1'b1;
    wdata[1] = 32'h00ab_00ab; wmask[1] = 4'b1011;
    tick();  // cycle 1
    chk("lit_wr_grant1", 32'(grant[1]), 32'd1);
    chk("lit_wr_we", 32'(bus_write_enable), 32'd1);
    chk("lit_wr_addr", 32'(bus_address), 32'h8002);
    chk("lit_wr_data", bus_data_in, 32'h00ab_00ab);
    chk("lit_wr_mask", 32'(bus_write_mask), 32'hb);
    tick();  // cycle 2
    chk("lit_wr_we_off", 32'(bus_write_enable), 32'd0);
    tick(); tick(); tick();  // cycle 5
    chk("lit_wr_done1", 32'(done[1]), 32'd1);
    chk("lit_wr_rdata1", rdata[1], 32'd0);
    req[1] = 1'b0;
    tick();

    // Reset during WAIT of an m0 read; afterwards a tie goes to m0.
    req[0] = 1'b1; addr[0] = 16'h1234; we[0] = 1'b0;
    tick(); tick();  // cycle 2, WAIT
    reset = 1'b1;
    tick();
    chk("lit_rstw_busy", 32'(busy), 32'd0);
    chk("lit_rstw_en", 32'(bus_enable), 32'd0);
    reset = 1'b0;
    req[1] = 1'b1; addr[1] = 16'h0040; we[1] = 1'b0;
    tick();
    chk("lit_tie_grant0", 32'(grant[0]), 32'd1);
    chk("lit_tie_grant1", 32'(grant[1]), 32'd0);

    // Both held: grants alternate.
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (grant[0]) order.push_back(0);
      if (grant[1]) order.push_back(1);
    end
    chk("lit_alt_count", 32'(order.size()), 32'd3);
    if (order.size() >= 3) begin
      chk("lit_alt_0", 32'(order[0]), 32'd1);
      chk("lit_alt_1", 32'(order[1]), 32'd0);
      chk("lit_alt_2", 32'(order[2]), 32'd1);
    end
    req = '0;
    repeat (8) tick();

    // Back-to-back m0 with m1 arriving mid-transaction.
    req[0] = 1'b1; addr[0] = 16'h0100; we[0] = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 2) begin
        req[1] = 1'b1; addr[1] = 16'h0200; we[1] = 1'b1;
      end
      if (grant[0]) g0.push_back(i);
      if (grant[1]) g1.push_back(i);
    end
    chk("lit_b2b_n0", 32'(g0.size()), 32'd2);
    chk("lit_b2b_n1", 32'(g1.size()), 32'd1);
    if (g0.size() == 2 && g1.size() == 1) begin
      chk("lit_b2b_g0a", 32'(g0[0]), 32'd1);
      chk("lit_b2b_g1", 32'(g1[0]), 32'(4 + L));
      chk("lit_b2b_g0b", 32'(g0[1]), 32'(4 + L + 6));
    end
    req = '0;
    repeat (8) tick();

    // Randomized masters.
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset = ($urandom_range(199) == 0);
      for (int k = 0; k < 2; k++) begin
        if (req[k]) begin
          if (e_done[k]) begin
            if ($urandom_range(3) == 0) new_fields(k);
            else req[k] = 1'b0;
          end
        end else if ($urandom_range(2) == 0) begin
          req[k] = 1'b1;
          new_fields(k);
        end
      end
    end
    reset = 1'b0;
    req = '0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
